// File: rtl/gpu_cmd_sequencer.sv
// gpu_cmd_sequencer: buffers {cmd,param} requests and serialises them onto the GPU command bus
//   clk         rising-edge clock
//   clr         async active-high reset (shared with the GPU)
//   req_valid   CPU request present; transfer on req_valid & req_ready
//   req_ready   FIFO has room
//   req_cmd     command code, legal range CMD_LO..CMD_HI
//   req_param   parameter word
//   cpuline     registered word on the GPU command bus, 0 when idle
//   busy        FIFO non-empty or a command sequence in flight
//   err_illegal single-cycle pulse when an illegal command is dropped
//   fifo_level  FIFO occupancy, 0..DEPTH
module gpu_cmd_sequencer #(
    parameter int          DEPTH  = 4,
    parameter int          AW     = 2,
    parameter logic [15:0] CMD_LO = 16'hC0,
    parameter logic [15:0] CMD_HI = 16'hC6
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [15:0]   req_cmd,
    input  logic [15:0]   req_param,
    output logic [15:0]   cpuline,
    output logic          busy,
    output logic          err_illegal,
    output logic [AW:0]   fifo_level
);
    typedef enum logic [2:0] {IDLE, ALIGN, CMD, PARAM, EXEC} state_t;
    state_t state, state_nxt;
    logic ph, ph_nxt, push, pop, empty, legal;
    logic [15:0] mem_cmd [DEPTH];
    logic [15:0] mem_param [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] level;
    logic [15:0] hold_cmd, hold_param, head_cmd, head_param, cpuline_nxt;

    always_comb begin
        head_cmd    = mem_cmd[rd_ptr];
        head_param  = mem_param[rd_ptr];
        empty       = level == '0;
        legal       = head_cmd >= CMD_LO && head_cmd <= CMD_HI;
        req_ready   = level < (AW+1)'(DEPTH);
        push        = req_valid && req_ready;
        // mirror of the GPU nopstate: toggles while it latches NOPs, word pair 0->1->0, exec slot pins it to 0
        ph_nxt      = (state == IDLE || state == ALIGN) ? ~ph : (state == CMD);
        state_nxt   = state;
        pop         = 1'b0;
        err_illegal = 1'b0;
        case (state)
            IDLE: if (!empty) begin
                pop = 1'b1;
                if (legal) state_nxt = ph_nxt ? ALIGN : CMD;
                else err_illegal = 1'b1;
            end
            ALIGN: state_nxt = CMD;
            CMD:   state_nxt = PARAM;
            PARAM: state_nxt = EXEC;
            EXEC: if (!empty && legal) begin
                pop = 1'b1;
                state_nxt = CMD;
            end else state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // CMD entered straight from a pop takes the head directly, since hold regs load on the same edge
        cpuline_nxt = state_nxt == CMD ? (pop ? head_cmd : hold_cmd) :
                      state_nxt == PARAM ? hold_param : 16'h0;
        busy        = !empty || state != IDLE;
        fifo_level  = level;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_cmd[wr_ptr]   <= req_cmd;
            mem_param[wr_ptr] <= req_param;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state      <= IDLE;
            ph         <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            hold_cmd   <= '0;
            hold_param <= '0;
            cpuline    <= '0;
        end else begin
            state   <= state_nxt;
            ph      <= ph_nxt;
            cpuline <= cpuline_nxt;
            level   <= level + (AW+1)'(push) - (AW+1)'(pop);
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) begin
                rd_ptr     <= rd_ptr + AW'(1);
                hold_cmd   <= head_cmd;
                hold_param <= head_param;
            end
        end
    end
endmodule
